// File: rtl/vx_mmul_accum_pkg.sv
// -----------------------------------------------------------------------------
// vx_mmul_accum_pkg
// Shared definitions for the MMUL commit accumulator:
//   - global widths of the commit stream (XLEN, UUID, register index)
//   - default warp / thread counts used to size the accumulator table
//   - beat classification enum and the fixed-width part of the commit tag
//   - small sizing helpers used by the top and the accumulator table
// -----------------------------------------------------------------------------
package vx_mmul_accum_pkg;

  localparam int XLEN           = 32;
  localparam int UUID_WIDTH     = 44;
  localparam int NR_BITS        = 5;
  localparam int NUM_WARPS_DFLT = 4;
  localparam int NUM_THREADS    = 4;

  // Classification of the beat currently offered on the input.
  typedef enum logic [1:0] {
    BEAT_IDLE    = 2'd0,
    BEAT_PARTIAL = 2'd1,
    BEAT_FINAL   = 2'd2
  } beat_class_e;

  // Tag fields whose width does not depend on the lane / warp parameters.
  // tmask, wid and pid travel beside this struct because their widths follow
  // the instance parameters.
  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [XLEN-1:0]       pc;
    logic [NR_BITS-1:0]    rd;
    logic                  wb;
    logic                  sop;
    logic                  eop;
  } commit_hdr_t;

  // ceil(log2(n)) with a minimum of one bit.
  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of one accumulator entry (all lanes of one warp).
  function automatic int acc_entry_w(input int lanes);
    return lanes * XLEN;
  endfunction

endpackage

// File: rtl/vx_mmul_acc_table.sv
// -----------------------------------------------------------------------------
// vx_mmul_acc_table
// Per-warp accumulator storage: NUM_WARPS entries of NUM_LANES x XLEN plus one
// busy bit per warp. One combinational read port, one synchronous write port.
//
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset (clears busy bits only)
//   i_rd_wid   in   warp to read
//   o_rd_data  out  entry of i_rd_wid, forced to zero when that warp is idle
//   i_wr_en    in   write strobe (one accepted beat)
//   i_wr_wid   in   warp to write
//   i_wr_busy  in   new busy value; the data word is stored only when 1
//   i_wr_data  in   new entry value
//   o_busy     out  busy bit per warp (registered state)
// -----------------------------------------------------------------------------
module vx_mmul_acc_table
  import vx_mmul_accum_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DFLT,
  parameter int NUM_LANES = 1,
  localparam int NW_W  = up_clog2(NUM_WARPS),
  localparam int ACC_W = acc_entry_w(NUM_LANES)
)(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NW_W-1:0]      i_rd_wid,
  output logic [ACC_W-1:0]     o_rd_data,
  input  logic                 i_wr_en,
  input  logic [NW_W-1:0]      i_wr_wid,
  input  logic                 i_wr_busy,
  input  logic [ACC_W-1:0]     i_wr_data,
  output logic [NUM_WARPS-1:0] o_busy
);

  logic [ACC_W-1:0]     r_acc [NUM_WARPS];
  logic [NUM_WARPS-1:0] r_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else if (i_wr_en) begin
      r_busy[i_wr_wid] <= i_wr_busy;
    end
  end

  // Data words carry no reset: an idle entry is never observed because the
  // read port masks it with the busy bit.
  always_ff @(posedge clk) begin
    if (i_wr_en && i_wr_busy) begin
      r_acc[i_wr_wid] <= i_wr_data;
    end
  end

  // A write at edge t is visible to the read in cycle t+1 with no bubble,
  // since the read port looks straight at the registered array.
  assign o_rd_data = r_busy[i_rd_wid] ? r_acc[i_rd_wid] : '0;
  assign o_busy    = r_busy;

endmodule

// File: rtl/vx_mmul_accum.sv
// -----------------------------------------------------------------------------
// vx_mmul_accum
// Sums MMUL partial products per warp and per lane between the muldiv response
// arbiter and the writeback arbiter. Partial beats (in_true_eop=0) update the
// warp's accumulator and produce no output; a final beat (in_true_eop=1) adds
// the open sum (zero if none) and emits one commit one cycle later. Non-MMUL
// results are finals with no open sum and simply pass through one register.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   in_valid / in_ready           input handshake (partials never stall)
//   in_uuid..in_eop, in_data      commit tag and per-lane data
//   in_true_eop                   0 = MMUL partial, 1 = final / normal result
//   out_valid / out_ready         output handshake
//   out_uuid..out_eop, out_data   registered commit tag and data
//   acc_busy                      per-warp open-accumulation flag
// -----------------------------------------------------------------------------
module vx_mmul_accum
  import vx_mmul_accum_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int NUM_WARPS = NUM_WARPS_DFLT,
  parameter int PID_WIDTH = up_clog2(NUM_THREADS / NUM_LANES),
  localparam int NW_W  = up_clog2(NUM_WARPS),
  localparam int ACC_W = acc_entry_w(NUM_LANES)
)(
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [UUID_WIDTH-1:0] in_uuid,
  input  logic [NW_W-1:0]       in_wid,
  input  logic [NUM_LANES-1:0]  in_tmask,
  input  logic [XLEN-1:0]       in_PC,
  input  logic [NR_BITS-1:0]    in_rd,
  input  logic                  in_wb,
  input  logic [PID_WIDTH-1:0]  in_pid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [ACC_W-1:0]      in_data,
  input  logic                  in_true_eop,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [UUID_WIDTH-1:0] out_uuid,
  output logic [NW_W-1:0]       out_wid,
  output logic [NUM_LANES-1:0]  out_tmask,
  output logic [XLEN-1:0]       out_PC,
  output logic [NR_BITS-1:0]    out_rd,
  output logic                  out_wb,
  output logic [PID_WIDTH-1:0]  out_pid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [ACC_W-1:0]      out_data,

  output logic [NUM_WARPS-1:0]  acc_busy
);

  // Lane add, modulo 2^XLEN with no saturation and no sign handling.
  function automatic logic [XLEN-1:0] add_wrap(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    return a + b;
  endfunction

  beat_class_e      w_class;
  logic             w_accept;
  logic             w_acc_partial;
  logic             w_acc_final;
  logic [ACC_W-1:0] w_acc_rd;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_new_data;

  logic             r_out_valid;
  commit_hdr_t      r_out_hdr;
  logic [NW_W-1:0]  r_out_wid;
  logic [NUM_LANES-1:0] r_out_tmask;
  logic [PID_WIDTH-1:0] r_out_pid;
  logic [ACC_W-1:0] r_out_data;

  always_comb begin
    w_class = BEAT_IDLE;
    if (in_valid) begin
      w_class = in_true_eop ? BEAT_FINAL : BEAT_PARTIAL;
    end
  end

  // Partials only touch the table, so they never wait on the output. Finals
  // wait only while the output register is full and not being drained.
  assign in_ready      = in_true_eop ? (~r_out_valid | out_ready) : 1'b1;
  assign w_accept      = in_valid & in_ready;
  assign w_acc_partial = w_accept & (w_class == BEAT_PARTIAL);
  assign w_acc_final   = w_accept & (w_class == BEAT_FINAL);

  vx_mmul_acc_table #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_LANES (NUM_LANES)
  ) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_rd_wid  (in_wid),
    .o_rd_data (w_acc_rd),
    .i_wr_en   (w_accept),
    .i_wr_wid  (in_wid),
    .i_wr_busy (w_acc_partial),
    .i_wr_data (w_new_data),
    .o_busy    (acc_busy)
  );

  // in_sop on a partial restarts the sum; the table already returns zero for
  // idle warps, so only the restart case needs masking here.
  assign w_base = (~in_true_eop & in_sop) ? '0 : w_acc_rd;

  // Masked-off lanes keep the old sum on a partial but forward the raw input
  // on a final, so an inactive lane never leaks a stale accumulator value.
  always_comb begin
    w_new_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (in_tmask[l]) begin
        w_new_data[l*XLEN +: XLEN] = add_wrap(w_base[l*XLEN +: XLEN],
                                              in_data[l*XLEN +: XLEN]);
      end else if (in_true_eop) begin
        w_new_data[l*XLEN +: XLEN] = in_data[l*XLEN +: XLEN];
      end else begin
        w_new_data[l*XLEN +: XLEN] = w_base[l*XLEN +: XLEN];
      end
    end
  end

  // Output register: loads on an accepted final (also on the edge it drains),
  // holds while stalled, empties once consumed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_hdr   <= '0;
      r_out_wid   <= '0;
      r_out_tmask <= '0;
      r_out_pid   <= '0;
      r_out_data  <= '0;
    end else if (w_acc_final) begin
      r_out_valid    <= 1'b1;
      r_out_hdr.uuid <= in_uuid;
      r_out_hdr.pc   <= in_PC;
      r_out_hdr.rd   <= in_rd;
      r_out_hdr.wb   <= in_wb;
      r_out_hdr.sop  <= in_sop;
      r_out_hdr.eop  <= in_eop;
      r_out_wid      <= in_wid;
      r_out_tmask    <= in_tmask;
      r_out_pid      <= in_pid;
      r_out_data     <= w_new_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_uuid  = r_out_hdr.uuid;
  assign out_PC    = r_out_hdr.pc;
  assign out_rd    = r_out_hdr.rd;
  assign out_wb    = r_out_hdr.wb;
  assign out_sop   = r_out_hdr.sop;
  assign out_eop   = r_out_hdr.eop;
  assign out_wid   = r_out_wid;
  assign out_tmask = r_out_tmask;
  assign out_pid   = r_out_pid;
  assign out_data  = r_out_data;

endmodule
